// File: rtl/gpio_control_pkg.sv
// Shared definitions for the GPIO-control Wishbone initiator: FSM states,
// register word offsets of the GPIO-control slave, and default sizing.
package gpio_control_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Byte base of the GPIO-control slave on the user Wishbone bus.
  localparam logic [31:0] GPIO_CTRL_BASE_DEFAULT = 32'h3000_0000;

  // Width of the STB-without-ACK timeout counter (supports up to 65535 cycles).
  localparam int TO_CNT_W = 16;

  // Word offsets inside the GPIO-control block.
  localparam logic [7:0] GPIO_OFF_XFER       = 8'h00;
  localparam logic [7:0] GPIO_OFF_PWR        = 8'h01;
  localparam logic [7:0] GPIO_OFF_PIN_SEL_LO = 8'h02;
  localparam logic [7:0] GPIO_OFF_PIN_SEL_HI = 8'h03;
  localparam logic [7:0] GPIO_OFF_PIN_CFG0   = 8'h08;
  localparam int         GPIO_NUM_PINS       = 38;

  // Word offset of the per-pin configuration register for a given pin.
  function automatic logic [7:0] pin_cfg_off(input logic [5:0] pin);
    return GPIO_OFF_PIN_CFG0 + {2'b00, pin};
  endfunction

endpackage

// File: rtl/gpio_control_wb_master.sv
// Wishbone classic initiator for the GPIO-control register block. Takes one
// read/write command at a time, runs a single STB/ACK transaction with a
// bounded wait, and returns read data or a timeout flag on the response port.
module gpio_control_wb_master
  import gpio_control_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = GPIO_CTRL_BASE_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  // command port
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [7:0]  cmd_off_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  // response port
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  // Wishbone initiator
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  // Counter value seen during the last permitted STB cycle.
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              r_state;
  logic [TO_CNT_W-1:0] r_cnt;
  logic [31:0]         w_adr;

  // Word offset scaled to bytes; the sum wraps at 32 bits by design.
  assign w_adr       = BASE_ADDR + {22'b0, cmd_off_i, 2'b00};
  assign cmd_ready_o = (r_state == ST_IDLE);

  // Transaction FSM with inline timeout counter; all bus/response outputs registered.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          // Bus qualifiers are loaded here and then held until the next command.
          if (cmd_valid_i) begin
            wbm_we_o  <= cmd_we_i;
            wbm_sel_o <= cmd_sel_i;
            wbm_dat_o <= cmd_dat_i;
            wbm_adr_o <= w_adr;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            r_cnt     <= '0;
            r_state   <= ST_BUS;
          end
        end
        ST_BUS: begin
          r_cnt <= r_cnt + 1'b1;
          // ACK takes priority over a timeout landing in the same cycle.
          if (wbm_ack_i) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_dat_o   <= wbm_we_o ? 32'h0 : wbm_dat_i;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            r_state     <= ST_RESP;
          end else if (r_cnt == TO_LAST) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_dat_o   <= 32'h0;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
